vector_store_unit: RTL
======================

VECTOR_STORE_UNIT -- requirements
Module: vector_store_unit

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32, giving the memory word width in bits.
REQ-002 The block SHALL have parameter LANES, default 4, giving the number of words per vector register; vector width is WORD_W*LANES (128).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  request to store one vector register; sampled only in IDLE.
REQ-006 base_addr  input  32  byte address of lane 0, sampled with start.
REQ-007 vdata  input  128  vector register read data, sampled with start.
REQ-008 mem_ready  input  1  memory accepts the current write in a cycle where mem_we=1 and mem_ready=1.
REQ-009 mem_we  output  1  memory write request.
REQ-010 mem_addr  output  32  byte address of the current write.
REQ-011 mem_wdata  output  32  data of the current write.
REQ-012 busy  output  1  high while a store is in progress (WRITE or DONE).
REQ-013 done  output  1  one-cycle pulse when all lanes are written.

Function
REQ-014 The FSM SHALL have states IDLE, WRITE and DONE, held in registers.
REQ-015 IDLE: if start=1, the block SHALL capture vdata and base_addr, set lane counter to 0, and enter WRITE next cycle; otherwise it stays in IDLE.
REQ-016 WRITE: mem_we SHALL be 1, mem_addr = captured base_addr + 4*lane (mod 2^32), and mem_wdata = captured vdata[32*lane+31 : 32*lane], with lane 0 = bits [31:0].
REQ-017 WRITE: if mem_ready=0, lane, mem_addr and mem_wdata SHALL hold unchanged (write stall).
REQ-018 WRITE: if mem_ready=1 and lane<LANES-1, lane SHALL increment by 1.
REQ-019 WRITE: if mem_ready=1 and lane=LANES-1, the FSM SHALL enter DONE.
REQ-020 DONE: done SHALL be 1 for exactly one cycle, mem_we SHALL be 0, and the FSM SHALL return to IDLE.
REQ-021 start asserted in WRITE or DONE SHALL be ignored; it is not queued. Changes to vdata or base_addr after capture SHALL NOT affect the store in progress.
REQ-022 mem_we SHALL be 0 in IDLE and DONE; busy SHALL be 1 exactly in WRITE and DONE.
REQ-023 With mem_ready held at 1, start in cycle N SHALL produce writes in cycles N+1..N+4, done in N+5, and accept a new start in N+6.
REQ-024 Address computation SHALL wrap modulo 2^32 with no error indication.
REQ-025 Exactly LANES accepted writes SHALL occur per accepted start, each address written exactly once, in ascending lane order.

Reset
REQ-026 With rst_n=0 at a rising clk edge, the FSM SHALL go to IDLE, lane to 0, and captured data and address to 0.
REQ-027 During and after reset, until the next start, mem_we, busy and done SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-028 Reset asserted mid-store SHALL abort the store immediately; remaining lanes SHALL NOT be written and done SHALL NOT pulse.
REQ-029 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Verification
REQ-030 Scenario: mem_ready=1; start with base_addr=0x100, vdata=0x44444444_33333333_22222222_11111111 -> writes (0x100,0x11111111), (0x104,0x22222222), (0x108,0x33333333), (0x10C,0x44444444) in consecutive cycles; done 1 cycle later.
REQ-031 Scenario: mem_ready low for 3 cycles during lane 2 -> mem_addr and mem_wdata held at 0x108/0x33333333; total 4 accepted writes; done delayed 3 cycles.
REQ-032 Scenario: base_addr=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-033 Scenario: start pulsed during WRITE and during DONE with different vdata -> ignored; only the first store's 4 words are written; busy is low for one cycle before the next accepted start.
REQ-034 Scenario: rst_n=0 after the lane-1 write is accepted -> next cycle mem_we=0, busy=0, done=0, and there is no write to base+8 or base+12.
REQ-035 Scenario: vdata changed the cycle after start -> written words match the vdata captured at start.

Source files
------------

// File: rtl/vector_store_unit.sv
// Vector store unit: splits one captured vector register into LANES word writes
// presented in ascending lane order, stalling on mem_ready.
module vector_store_unit #(
    parameter int WORD_W = 32,
    parameter int LANES  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [31:0]               base_addr,
    input  logic [WORD_W*LANES-1:0]   vdata,
    input  logic                      mem_ready,
    output logic                      mem_we,
    output logic [31:0]               mem_addr,
    output logic [WORD_W-1:0]         mem_wdata,
    output logic                      busy,
    output logic                      done
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    logic [1:0]               state_q, state_d;
    logic [LANE_W-1:0]        lane_q, lane_d;
    logic [31:0]              base_q, base_d;
    logic [WORD_W*LANES-1:0]  data_q, data_d;
    logic [31:0]              lane_offset;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        base_d  = base_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WRITE;
                    lane_d  = '0;
                    base_d  = base_addr;
                    data_d  = vdata;
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    if (lane_q == LAST_LANE) begin
                        state_d = S_DONE;
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are forced to zero outside WRITE so the bus is quiet between stores.
    always_comb begin
        lane_offset = {{(30 - LANE_W){1'b0}}, lane_q, 2'b00};
        mem_we      = (state_q == S_WRITE);
        busy        = (state_q == S_WRITE) || (state_q == S_DONE);
        done        = (state_q == S_DONE);
        mem_addr    = '0;
        mem_wdata   = '0;
        if (mem_we) begin
            mem_addr  = base_q + lane_offset;
            mem_wdata = data_q[int'(lane_q)*WORD_W +: WORD_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            base_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            base_q  <= base_d;
            data_q  <= data_d;
        end
    end

endmodule
